// File: rtl/e_mdu_ctrl_pkg.sv
// e_mdu_ctrl_pkg: HI/LO op encodings and multiply/divide sequencer state codes
package e_mdu_ctrl_pkg;
  typedef enum logic [3:0] {
    HILO_NONE  = 4'd0,
    HILO_MULT  = 4'd1,
    HILO_MULTU = 4'd2,
    HILO_DIV   = 4'd3,
    HILO_DIVU  = 4'd4,
    HILO_MTHI  = 4'd5,
    HILO_MTLO  = 4'd6
  } hilo_op_e;
  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;
endpackage

// File: rtl/e_mdu_arith.sv
// e_mdu_arith: combinational mult/multu/div/divu result and divide-by-zero flag
module e_mdu_arith
  import e_mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);
  logic [63:0] ps, pu;
  logic [31:0] ua, ub, q, r;
  logic na, nb;
  assign ps = {{32{num1[31]}}, num1} * {{32{num2[31]}}, num2};
  assign pu = {32'b0, num1} * {32'b0, num2};
  // signed divide runs on magnitudes so 0x80000000 / -1 falls out without overflow
  assign na = (op == HILO_DIV) && num1[31];
  assign nb = (op == HILO_DIV) && num2[31];
  assign ua = na ? -num1 : num1;
  assign ub = nb ? -num2 : num2;
  assign q  = (ub == 32'd0) ? 32'd0 : ua / ub;
  assign r  = (ub == 32'd0) ? 32'd0 : ua % ub;
  assign div0 = (op == HILO_DIV || op == HILO_DIVU) && num2 == 32'd0;
  always_comb begin
    res_hi = (op == HILO_MULT) ? ps[63:32] : (op == HILO_MULTU) ? pu[63:32] : na ? -r : r;
    res_lo = (op == HILO_MULT) ? ps[31:0] : (op == HILO_MULTU) ? pu[31:0] : (na ^ nb) ? -q : q;
  end
endmodule

// File: rtl/e_mdu_ctrl.sv
// e_mdu_ctrl: E-stage mult/div sequencer with fixed latency and HI/LO register pair
module e_mdu_ctrl
  import e_mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_num1,
  input  logic [31:0] in_num2,
  output logic        out_start,
  output logic        out_busy,
  output logic [31:0] out_hi,
  output logic [31:0] out_lo,
  output logic        out_drop
);
  localparam int CW = $clog2(MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1;
  mdu_state_e  state;
  logic [CW-1:0] cnt;
  logic [31:0] a_hi, a_lo, res_hi, res_lo;
  logic a_div0, div0, is_mult;
  e_mdu_arith u_arith (
    .op(in_op),
    .num1(in_num1),
    .num2(in_num2),
    .res_hi(a_hi),
    .res_lo(a_lo),
    .div0(a_div0)
  );
  assign is_mult = in_op == HILO_MULT || in_op == HILO_MULTU;
  assign out_start = !reset && in_valid && state == MDU_IDLE &&
                     (is_mult || in_op == HILO_DIV || in_op == HILO_DIVU);
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MDU_IDLE;
      cnt      <= '0;
      out_hi   <= '0;
      out_lo   <= '0;
      out_busy <= 1'b0;
      out_drop <= 1'b0;
      res_hi   <= '0;
      res_lo   <= '0;
      div0     <= 1'b0;
    end else begin
      out_drop <= in_valid && in_op != HILO_NONE && state == MDU_BUSY;
      if (state == MDU_IDLE) begin
        if (out_start) begin
          state    <= MDU_BUSY;
          out_busy <= 1'b1;
          cnt      <= is_mult ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
          res_hi   <= a_hi;
          res_lo   <= a_lo;
          div0     <= a_div0;
        end else if (in_valid && in_op == HILO_MTHI) out_hi <= in_num1;
        else if (in_valid && in_op == HILO_MTLO) out_lo <= in_num1;
      end else if (cnt == '0) begin
        state    <= MDU_IDLE;
        out_busy <= 1'b0;
        if (!div0) begin
          out_hi <= res_hi;
          out_lo <= res_lo;
        end
      end else cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_e_mdu_ctrl.sv
// tb_e_mdu_ctrl: directed and random checks of e_mdu_ctrl against a cycle-level behavioural model
module tb_e_mdu_ctrl;
  import e_mdu_ctrl_pkg::*;
  localparam int MC = 5;
  localparam int DC = 10;
  logic clk = 1'b0, reset, in_valid, out_start, out_busy, out_drop;
  logic [3:0] in_op;
  logic [31:0] in_num1, in_num2, out_hi, out_lo;
  int n_cmp = 0, n_bad = 0;
  int rem = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  logic m_drop = 0, p_div0 = 0;
  e_mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op),
    .in_num1(in_num1), .in_num2(in_num2), .out_start(out_start),
    .out_busy(out_busy), .out_hi(out_hi), .out_lo(out_lo), .out_drop(out_drop)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    p_div0 = 1'b0;
    if (op == HILO_MULT) begin
      q = sa * sb;
      p_hi = q[63:32];
      p_lo = q[31:0];
    end else if (op == HILO_MULTU) begin
      pu = ua * ub;
      p_hi = pu[63:32];
      p_lo = pu[31:0];
    end else if (b == 0) p_div0 = 1'b1;
    else if (op == HILO_DIV) begin
      q = sa / sb;
      r = sa % sb;
      p_hi = r[31:0];
      p_lo = q[31:0];
    end else begin
      uq = ua / ub;
      ur = ua % ub;
      p_hi = ur[31:0];
      p_lo = uq[31:0];
    end
  endtask
  task automatic step(input logic rst, input logic v, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    logic md;
    reset = rst; in_valid = v; in_op = op; in_num1 = a; in_num2 = b;
    @(negedge clk);
    md = v && (op == HILO_MULT || op == HILO_MULTU || op == HILO_DIV || op == HILO_DIVU);
    chk("start", 32'(out_start), 32'(!rst && md && rem == 0));
    chk("busy", 32'(out_busy), 32'(rem > 0));
    chk("drop", 32'(out_drop), 32'(m_drop));
    chk("hi", out_hi, m_hi);
    chk("lo", out_lo, m_lo);
    if (rst) begin
      rem = 0; m_hi = 0; m_lo = 0; m_drop = 0;
    end else begin
      m_drop = v && op != HILO_NONE && rem > 0;
      if (rem > 0) begin
        rem--;
        if (rem == 0 && !p_div0) begin
          m_hi = p_hi;
          m_lo = p_lo;
        end
      end else if (md) begin
        rem = (op == HILO_MULT || op == HILO_MULTU) ? MC : DC;
        calc(op, a, b);
      end else if (v && op == HILO_MTHI) m_hi = a;
      else if (v && op == HILO_MTLO) m_lo = a;
    end
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, HILO_NONE, $urandom, $urandom);
  endtask
  initial begin
    reset = 1; in_valid = 0; in_op = 0; in_num1 = 0; in_num2 = 0;
    @(posedge clk); #1;
    step(1, 0, HILO_NONE, 0, 0);
    idle(1);
    step(0, 1, HILO_MULT, 32'hFFFFFFFE, 3);
    idle(MC);
    chk("t1_hi", out_hi, 32'hFFFFFFFF);
    chk("t1_lo", out_lo, 32'hFFFFFFFA);
    chk("t1_busy", 32'(out_busy), 0);
    step(0, 1, HILO_DIVU, 100, 7);
    idle(DC);
    chk("t2_hi", out_hi, 2);
    chk("t2_lo", out_lo, 14);
    step(0, 1, HILO_DIV, 32'hFFFFFFF9, 2);
    idle(DC);
    chk("t2s_hi", out_hi, 32'hFFFFFFFF);
    chk("t2s_lo", out_lo, 32'hFFFFFFFD);
    step(0, 1, HILO_DIV, 32'h80000000, 32'hFFFFFFFF);
    idle(DC);
    chk("ovf_hi", out_hi, 0);
    chk("ovf_lo", out_lo, 32'h80000000);
    step(0, 1, HILO_MTHI, 32'h11, 0);
    step(0, 1, HILO_MTLO, 32'h22, 0);
    step(0, 1, HILO_DIV, 5, 0);
    idle(DC);
    chk("t3_hi", out_hi, 32'h11);
    chk("t3_lo", out_lo, 32'h22);
    step(0, 1, HILO_MULT, 7, 6);
    step(0, 1, HILO_MTLO, 32'hDEAD, 0);
    chk("t4_drop", 32'(out_drop), 1);
    idle(MC - 1);
    chk("t4_lo", out_lo, 42);
    step(0, 1, HILO_MTLO, 32'hDEAD, 0);
    chk("t4_mtlo", out_lo, 32'hDEAD);
    step(0, 1, HILO_DIV, 1000, 3);
    idle(2);
    step(1, 0, HILO_NONE, 0, 0);
    chk("t5_hi", out_hi, 0);
    chk("t5_busy", 32'(out_busy), 0);
    idle(DC + 2);
    chk("t5_lo", out_lo, 0);
    step(0, 1, HILO_MULT, 32'h12345678, 32'h9ABCDEF0);
    idle(MC - 1);
    step(0, 0, HILO_NONE, 0, 0);
    step(0, 1, HILO_MULTU, 2, 2);
    idle(MC);
    chk("t6_hi", out_hi, 0);
    chk("t6_lo", out_lo, 4);
    step(0, 0, HILO_MULT, 9, 9);
    chk("t6_nostart", 32'(out_busy), 0);
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFF : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      step($urandom_range(0, 80) == 0, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 7)), a, b);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
